// File: rtl/down_counter_timer_pkg.sv
// Shared state encoding for the down-counter/timer and its helpers.
package down_counter_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// Prescale divider: emits one tick every pre_reg+1 cycles while run is high.
module down_counter_timer_tick_prescaler #(
   parameter int PRESCALE_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     load,
   input  logic                     run,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic                     tick
);

   logic [PRESCALE_BITS-1:0] pre_cnt;
   logic [PRESCALE_BITS-1:0] pre_reg;

   assign tick = run && (pre_cnt == pre_reg);

   // The divider setting is only captured on load, so mid-run prescale changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         pre_reg <= '0;
      end else begin
         if (load) begin
            pre_reg <= prescale;
         end
         if (clear) begin
            pre_cnt <= '0;
         end else if (run) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, prescaled down-counter with one-cycle done pulse and optional auto-reload.
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int BITS          = 8,
   parameter int PRESCALE_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [BITS-1:0]          load_val,
   input  logic [PRESCALE_BITS-1:0] prescale,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     auto_reload,
   output logic [BITS-1:0]          Q,
   output logic                     busy,
   output logic                     done,
   output logic                     zero
);

   state_t          state;
   state_t          next_state;
   logic [BITS-1:0] reload_reg;
   logic [BITS-1:0] next_q;
   logic [BITS-1:0] next_reload;
   logic            next_done;
   logic            tick;
   logic            load_nonzero;

   assign load_nonzero = (load_val != '0);
   assign zero         = (Q == '0);

   down_counter_timer_tick_prescaler #(
      .PRESCALE_BITS(PRESCALE_BITS)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (stop || start),
      .load     (start && !stop && load_nonzero),
      .run      (state == ST_RUN),
      .prescale (prescale),
      .tick     (tick)
   );

   // Priority is stop over start over tick; a zero-valued start completes without entering RUN.
   always_comb begin
      next_state  = state;
      next_q      = Q;
      next_reload = reload_reg;
      next_done   = 1'b0;
      if (stop) begin
         next_state = ST_IDLE;
      end else if (start) begin
         if (load_nonzero) begin
            next_q      = load_val;
            next_reload = load_val;
            next_state  = ST_RUN;
         end else begin
            next_q     = '0;
            next_done  = 1'b1;
            next_state = ST_IDLE;
         end
      end else if (state == ST_RUN && tick) begin
         if (Q > BITS'(1)) begin
            next_q = Q - 1'b1;
         end else begin
            next_done = 1'b1;
            if (auto_reload) begin
               next_q = reload_reg;
            end else begin
               next_q     = '0;
               next_state = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         Q          <= '0;
         reload_reg <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= next_state;
         Q          <= next_q;
         reload_reg <= next_reload;
         busy       <= (next_state == ST_RUN);
         done       <= next_done;
      end
   end

endmodule
